// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a 4-bit universal shift register (194-style) through
// load, clear, shift and rotate operations issued over a valid/ready command port.
//
// Ports:
//   CLK        system clock, all state on rising edge
//   RST        synchronous reset, active-high
//   CMD_VALID  command request; accepted when CMD_VALID & CMD_READY at an edge
//   CMD_READY  high only while idle and out of reset
//   CMD_OP     000 NOP, 001 SHR, 010 SHL, 011 LOAD, 100 CLEAR, 101 ROR, 110 ROL, 111 reserved
//   CMD_CNT    shift count, 0 means 8
//   CMD_DATA   parallel load value
//   CMD_FILL   serial fill bit for SHR/SHL
//   SR_Q       shift register contents, used as rotate feedback
//   SR_MR_N    active-low clear to the shift register
//   SR_S       mode: 00 hold, 01 right (in at bit 0), 10 left (in at bit 3), 11 load
//   SR_D       serial inputs: [1] right-shift input, [0] left-shift input
//   SR_IN      parallel data to the shift register
//   BUSY       operation in progress (inverse of CMD_READY)
//   DONE       one-cycle completion pulse
//   ERR        one-cycle pulse alongside DONE for the reserved op
module shift_seq_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [2:0] CMD_CNT,
  input  logic [0:3] CMD_DATA,
  input  logic       CMD_FILL,
  input  logic [0:3] SR_Q,
  output logic       SR_MR_N,
  output logic [1:0] SR_S,
  output logic [1:0] SR_D,
  output logic [0:3] SR_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StClear = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpShr   = 3'b001;
  localparam logic [2:0] OpShl   = 3'b010;
  localparam logic [2:0] OpLoad  = 3'b011;
  localparam logic [2:0] OpClear = 3'b100;
  localparam logic [2:0] OpRor   = 3'b101;
  localparam logic [2:0] OpRol   = 3'b110;
  localparam logic [2:0] OpRsvd  = 3'b111;

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] op_q;
  logic [0:3] data_q;
  logic       fill_q;
  logic       accept;

  // Only the end bits of SR_Q feed the rotate paths.
  logic unused_sr_q;
  assign unused_sr_q = ^SR_Q[1:2];

  assign accept = CMD_VALID & CMD_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Count of 0 wraps to 7, giving 8 shift cycles.
          cnt_d = CMD_CNT - 3'd1;
          unique case (CMD_OP)
            OpLoad:                     state_d = StLoad;
            OpClear:                    state_d = StClear;
            OpShr, OpShl, OpRor, OpRol: state_d = StShift;
            OpNop, OpRsvd:              state_d = StFin;
            default:                    state_d = StFin;
          endcase
        end
      end
      StLoad, StClear: state_d = StFin;
      StShift: begin
        if (cnt_q == 3'd0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      op_q    <= OpNop;
      data_q  <= 4'b0000;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= CMD_OP;
        data_q <= CMD_DATA;
        fill_q <= CMD_FILL;
      end
    end
  end

  always_comb begin
    CMD_READY = 1'b0;
    SR_MR_N   = 1'b1;
    SR_S      = 2'b00;
    SR_D      = 2'b00;
    SR_IN     = data_q;
    DONE      = 1'b0;
    ERR       = 1'b0;
    if (RST) begin
      // Outputs are forced while reset is held so the register clears in step.
      SR_MR_N = 1'b0;
      SR_IN   = 4'b0000;
    end else begin
      unique case (state_q)
        StIdle:  CMD_READY = 1'b1;
        StLoad:  SR_S = 2'b11;
        StClear: SR_MR_N = 1'b0;
        StShift: begin
          unique case (op_q)
            OpShr: begin
              SR_S = 2'b01;
              SR_D = {fill_q, 1'b0};
            end
            OpRor: begin
              SR_S = 2'b01;
              SR_D = {SR_Q[3], 1'b0};
            end
            OpShl: begin
              SR_S = 2'b10;
              SR_D = {1'b0, fill_q};
            end
            OpRol: begin
              SR_S = 2'b10;
              SR_D = {1'b0, SR_Q[0]};
            end
            default: ;
          endcase
        end
        StFin: begin
          DONE = 1'b1;
          ERR  = (op_q == OpRsvd);
        end
        default: ;
      endcase
    end
  end

  assign BUSY = ~CMD_READY;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [2:0] CMD_CNT;
  logic [0:3] CMD_DATA;
  logic       CMD_FILL;
  logic [0:3] SR_Q;
  logic       SR_MR_N;
  logic [1:0] SR_S;
  logic [1:0] SR_D;
  logic [0:3] SR_IN;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: register contents as a number with SR_Q[0] as MSB,
  // and the data of the most recently accepted command.
  logic [3:0] mv;
  logic [3:0] last_data;

  always #5 CLK = ~CLK;

  shift_seq_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_CNT   (CMD_CNT),
    .CMD_DATA  (CMD_DATA),
    .CMD_FILL  (CMD_FILL),
    .SR_Q      (SR_Q),
    .SR_MR_N   (SR_MR_N),
    .SR_S      (SR_S),
    .SR_D      (SR_D),
    .SR_IN     (SR_IN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  // Behavioural 4-bit universal shift register driven by the controller.
  always_ff @(posedge CLK) begin
    if (!SR_MR_N) begin
      SR_Q <= 4'b0000;
    end else begin
      case (SR_S)
        2'b01:   SR_Q <= {SR_D[1], SR_Q[0:2]};
        2'b10:   SR_Q <= {SR_Q[1:3], SR_D[0]};
        2'b11:   SR_Q <= SR_IN;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int active_cycles(input logic [2:0] op, input logic [2:0] cnt);
    case (op)
      3'b011, 3'b100:                 return 1;
      3'b001, 3'b010, 3'b101, 3'b110: return (cnt == 3'd0) ? 8 : int'(cnt);
      default:                        return 0;
    endcase
  endfunction

  // Issue one command and check every cycle up to the return to idle.
  // With hold set, CMD_VALID stays high and the fields are scrambled while busy.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic fill, input bit hold);
    int         waited;
    int         n_act;
    logic [1:0] exp_s;
    logic [1:0] exp_d;
    logic       exp_mr;
    waited = 0;
    while (!CMD_READY && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check("ready_wait", 32'(CMD_READY), 32'(1));
    check("idle_busy", 32'(BUSY), 32'(0));
    check("idle_s", 32'(SR_S), 32'(0));
    check("idle_d", 32'(SR_D), 32'(0));
    check("idle_mr", 32'(SR_MR_N), 32'(1));
    check("idle_in", 32'(SR_IN), 32'(last_data));
    check("idle_q", 32'(SR_Q), 32'(mv));
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_CNT   = cnt;
    CMD_DATA  = data;
    CMD_FILL  = fill;
    @(negedge CLK);
    last_data = data;
    n_act     = active_cycles(op, cnt);
    for (int k = 0; k < n_act; k++) begin
      exp_s  = 2'b00;
      exp_d  = 2'b00;
      exp_mr = 1'b1;
      case (op)
        3'b011: exp_s = 2'b11;
        3'b100: exp_mr = 1'b0;
        3'b001: begin exp_s = 2'b01; exp_d = {fill, 1'b0};  end
        3'b101: begin exp_s = 2'b01; exp_d = {mv[0], 1'b0}; end
        3'b010: begin exp_s = 2'b10; exp_d = {1'b0, fill};  end
        3'b110: begin exp_s = 2'b10; exp_d = {1'b0, mv[3]}; end
        default: ;
      endcase
      check("act_busy", 32'(BUSY), 32'(1));
      check("act_ready", 32'(CMD_READY), 32'(0));
      check("act_done", 32'(DONE), 32'(0));
      check("act_s", 32'(SR_S), 32'(exp_s));
      check("act_d", 32'(SR_D), 32'(exp_d));
      check("act_mr", 32'(SR_MR_N), 32'(exp_mr));
      check("act_in", 32'(SR_IN), 32'(data));
      check("act_q", 32'(SR_Q), 32'(mv));
      case (op)
        3'b011: mv = data;
        3'b100: mv = 4'b0000;
        3'b001: mv = 4'((fill ? 8 : 0) + (mv / 2));
        3'b010: mv = 4'((mv * 2) % 16 + (fill ? 1 : 0));
        3'b101: mv = 4'((mv % 2) * 8 + (mv / 2));
        3'b110: mv = 4'((mv * 2) % 16 + (mv / 8));
        default: ;
      endcase
      if (hold) begin
        CMD_OP   = 3'($urandom);
        CMD_CNT  = 3'($urandom);
        CMD_DATA = 4'($urandom);
        CMD_FILL = 1'($urandom);
      end else begin
        CMD_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    check("fin_done", 32'(DONE), 32'(1));
    check("fin_err", 32'(ERR), 32'(op == 3'b111));
    check("fin_busy", 32'(BUSY), 32'(1));
    check("fin_s", 32'(SR_S), 32'(0));
    check("fin_d", 32'(SR_D), 32'(0));
    check("fin_in", 32'(SR_IN), 32'(data));
    check("fin_q", 32'(SR_Q), 32'(mv));
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check("post_done", 32'(DONE), 32'(0));
    check("post_err", 32'(ERR), 32'(0));
    check("post_ready", 32'(CMD_READY), 32'(1));
    check("post_in", 32'(SR_IN), 32'(data));
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_mr"}, 32'(SR_MR_N), 32'(0));
    check({tag, "_s"}, 32'(SR_S), 32'(0));
    check({tag, "_d"}, 32'(SR_D), 32'(0));
    check({tag, "_in"}, 32'(SR_IN), 32'(0));
    check({tag, "_done"}, 32'(DONE), 32'(0));
    check({tag, "_err"}, 32'(ERR), 32'(0));
    check({tag, "_ready"}, 32'(CMD_READY), 32'(0));
  endtask

  initial begin
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP    = 3'b000;
    CMD_CNT   = 3'd0;
    CMD_DATA  = 4'b0000;
    CMD_FILL  = 1'b0;
    mv        = 4'b0000;
    last_data = 4'b0000;

    // Two reset cycles, then release.
    @(negedge CLK);
    check_in_reset("rst1");
    @(negedge CLK);
    check_in_reset("rst2");
    RST = 1'b0;
    #1;
    check("rst_rel_ready", 32'(CMD_READY), 32'(1));
    check("rst_rel_mr", 32'(SR_MR_N), 32'(1));
    @(negedge CLK);
    check("rst_q", 32'(SR_Q), 32'(0));

    // Directed cases.
    run_cmd(3'b011, 3'd0, 4'b1010, 1'b0, 1'b0);
    check("load_1010", 32'(SR_Q), 32'(4'b1010));
    run_cmd(3'b011, 3'd0, 4'b0001, 1'b0, 1'b0);
    run_cmd(3'b001, 3'd3, 4'b0000, 1'b1, 1'b0);
    check("shr3_fill1", 32'(SR_Q), 32'(4'b1110));
    run_cmd(3'b011, 3'd0, 4'b1000, 1'b0, 1'b0);
    run_cmd(3'b110, 3'd0, 4'b0110, 1'b0, 1'b0);
    check("rol8", 32'(SR_Q), 32'(4'b1000));
    run_cmd(3'b111, 3'd5, 4'b0011, 1'b1, 1'b1);
    check("rsvd_q", 32'(SR_Q), 32'(4'b1000));
    run_cmd(3'b100, 3'd2, 4'b1111, 1'b0, 1'b1);
    check("clear_q", 32'(SR_Q), 32'(0));

    // Randomized commands with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      run_cmd(3'($urandom), 3'($urandom), 4'($urandom), 1'($urandom),
              1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // Reset in the second cycle of SHR CNT=5 aborts without DONE.
    run_cmd(3'b011, 3'd0, 4'b0110, 1'b0, 1'b0);
    CMD_VALID = 1'b1;
    CMD_OP    = 3'b001;
    CMD_CNT   = 3'd5;
    CMD_DATA  = 4'b0101;
    CMD_FILL  = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    check("abort_s1", 32'(SR_S), 32'(1));
    @(negedge CLK);
    check("abort_s2", 32'(SR_S), 32'(1));
    RST = 1'b1;
    #1;
    check_in_reset("abort_a");
    @(negedge CLK);
    check_in_reset("abort_b");
    RST = 1'b0;
    #1;
    check("abort_ready", 32'(CMD_READY), 32'(1));
    check("abort_done", 32'(DONE), 32'(0));
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_mr", 32'(SR_MR_N), 32'(1));
    check("abort_q", 32'(SR_Q), 32'(0));
    mv        = 4'b0000;
    last_data = 4'b0000;
    @(negedge CLK);
    run_cmd(3'b101, 3'd2, 4'b1001, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and use a synchronous, active-high reset.
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  high only in IDLE; a command is accepted on any edge where CMD_VALID and CMD_READY are both 1.
REQ-006 CMD_OP  input  3  operation code: 000 NOP, 001 SHR, 010 SHL, 011 LOAD, 100 CLEAR, 101 ROR, 110 ROL, 111 reserved.
REQ-007 CMD_CNT  input  3  shift count; 0 SHALL mean 8.
REQ-008 CMD_DATA  input  [0:3]  parallel load value.
REQ-009 CMD_FILL  input  1  serial fill bit for SHR/SHL.
REQ-010 SR_Q  input  [0:3]  current shift-register contents, used as rotate feedback.
REQ-011 SR_MR_N  output  1  active-low clear to the shift register.
REQ-012 SR_S  output  2  mode select: 00 hold, 01 shift right (serial in at bit 0), 10 shift left (serial in at bit 3), 11 parallel load.
REQ-013 SR_D  output  2  serial inputs: D[1] is the right-shift input and D[0] is the left-shift input.
REQ-014 SR_IN  output  [0:3]  parallel data to the shift register.
REQ-015 BUSY / DONE / ERR  output  1 each  operation in progress / one-cycle completion pulse / one-cycle reserved-op pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT, CLEAR and FIN.
REQ-017 Transitions from IDLE on accept SHALL be:
- LOAD for 011
- CLEAR for 100
- SHIFT for 001, 010, 101 and 110
- FIN for 000 and 111
REQ-018 The op, count, data and fill SHALL be latched on accept; input changes while BUSY SHALL have no effect.
REQ-019 Active cycles are the cycles spent in LOAD, SHIFT or CLEAR; the shift register samples SR_* at the end of each active cycle.
REQ-020 LOAD SHALL last exactly 1 cycle with SR_S=11 and SR_IN equal to the latched data, then go to FIN.
REQ-021 CLEAR SHALL last exactly 1 cycle with SR_MR_N=0 and SR_S=00, then go to FIN.
REQ-022 SHIFT SHALL last exactly N cycles, where N is the latched count (1..8); a 3-bit down-counter SHALL reach terminal count, then go to FIN.
- SR_S SHALL be 01 for SHR/ROR and 10 for SHL/ROL.
REQ-023 SR_D sourcing during SHIFT SHALL be:
- SHR: D[1] = fill
- SHL: D[0] = fill
- ROR: D[1] = SR_Q[3], combinational
- ROL: D[0] = SR_Q[0], combinational
- Unused D bits = 0.
REQ-024 FIN SHALL last exactly 1 cycle and then return to IDLE:
- DONE=1, SR_S=00
- ERR=1 if the latched op is 111
REQ-025 Outside active cycles: SR_S=00, SR_D=00, SR_MR_N=1, SR_IN = last latched data.
REQ-026 BUSY SHALL equal the inverse of CMD_READY; back-to-back commands SHALL have at least 1 IDLE cycle between them.
REQ-027 NOP and reserved ops SHALL produce no active cycle; latency from accept to DONE SHALL be 1 cycle.
REQ-028 Latency from accept to DONE SHALL be:
- LOAD/CLEAR: 2 cycles
- shifts: N+1 cycles
- SR_Q SHALL be final at DONE.

Reset
REQ-029 While RST=1: state=IDLE, SR_MR_N=0, SR_S=00, SR_D=00, SR_IN=0000, DONE=0, ERR=0, CMD_READY=0.
REQ-030 In the first cycle after RST deasserts: CMD_READY=1, SR_MR_N=1.
REQ-031 RST asserted mid-operation SHALL abort at the next edge with no DONE pulse.

Verification
REQ-032 RST for 2 cycles -> SR_MR_N=0 and SR_S=00 during reset; CMD_READY=1 and SR_Q=0000 after.
REQ-033 LOAD 1010 -> 1 cycle with SR_S=11, SR_IN=1010; DONE 2 cycles after accept; SR_Q=1010.
REQ-034 SR_Q=0001, SHR CNT=3 FILL=1 -> SR_S=01 for exactly 3 cycles; SR_Q=1110 at DONE.
REQ-035 SR_Q=1000, ROL CNT=0 -> SR_S=10 for 8 cycles; SR_Q=1000 at DONE, 9 cycles after accept.
REQ-036 Op 111 -> no SR_S activity; DONE and ERR pulse together 1 cycle after accept; CMD_VALID held during BUSY is not accepted.
REQ-037 RST in the 2nd cycle of a SHR CNT=5 -> next cycle IDLE, SR_S=00, SR_MR_N=0, no DONE.
